// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the pipelined register file.
//   DEFAULT_DATA_W / DEFAULT_REG_CNT : default parameter values
//   DEFAULT_ADDR_W                   : index width for the default register count
//   reg_idx_t                        : register index type (default sizing)
//   ZERO_REG_IDX                     : index of the optional hardwired-zero register
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W  = 8;
  localparam int unsigned DEFAULT_REG_CNT = 4;
  localparam int unsigned DEFAULT_ADDR_W  = $clog2(DEFAULT_REG_CNT);

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

  localparam int unsigned ZERO_REG_IDX = 0;

endpackage

// File: rtl/regfile_pipe_if.sv
// regfile_pipe_if: decode/writeback bus of the register file.
//   master : pipeline side (drives indices, strobes, write data)
//   slave  : register file side (returns read data, busy and conflict flags)
// Signals:
//   rs, rt, rd_en          read indices and capture strobe
//   rs_val, rt_val         registered read data
//   rs_busy, rt_busy       registered busy flags of the addressed registers
//   rsv_en, rsv_reg        destination reservation
//   rsv_conflict           one-cycle pulse: reservation hit a busy register
//   is_write, reg_write,
//   write_val              writeback port
interface regfile_pipe_if #(
  parameter int unsigned DATA_W  = regfile_pkg::DEFAULT_DATA_W,
  parameter int unsigned REG_CNT = regfile_pkg::DEFAULT_REG_CNT
);
  localparam int unsigned ADDR_W = $clog2(REG_CNT);

  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              rd_en;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              rs_busy;
  logic              rt_busy;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_reg;
  logic              rsv_conflict;
  logic              is_write;
  logic [ADDR_W-1:0] reg_write;
  logic [DATA_W-1:0] write_val;

  modport master (
    output rs, rt, rd_en, rsv_en, rsv_reg, is_write, reg_write, write_val,
    input  rs_val, rt_val, rs_busy, rt_busy, rsv_conflict
  );

  modport slave (
    input  rs, rt, rd_en, rsv_en, rsv_reg, is_write, reg_write, write_val,
    output rs_val, rt_val, rs_busy, rt_busy, rsv_conflict
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for in-flight producers.
//   clk, rst            clock, asynchronous active-high reset
//   rs, rt, rd_en       read indices; busy flags captured when rd_en is high
//   rsv_en, rsv_reg     reservation (sets busy)
//   is_write, reg_write writeback (clears busy)
//   rs_busy, rt_busy    registered busy flags (next-state forwarded)
//   rsv_conflict        registered pulse when reserving an already-busy register
// Optional: REGFILE_ZERO_REG_EN makes register 0 never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned REG_CNT = DEFAULT_REG_CNT,
  localparam int unsigned ADDR_W  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              rd_en,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_reg,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] reg_write,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              rsv_conflict
);

  logic [REG_CNT-1:0] busy;
  logic [REG_CNT-1:0] busy_next;
  logic               rsv_eff;
  logic               wr_eff;

  always_comb begin
`ifdef REGFILE_ZERO_REG_EN
    rsv_eff = rsv_en   && (rsv_reg   != ADDR_W'(ZERO_REG_IDX));
    wr_eff  = is_write && (reg_write != ADDR_W'(ZERO_REG_IDX));
`else
    rsv_eff = rsv_en;
    wr_eff  = is_write;
`endif
    busy_next = busy;
    // Clear first, then set: a new producer supersedes the completing one.
    if (wr_eff)  busy_next[reg_write] = 1'b0;
    if (rsv_eff) busy_next[rsv_reg]   = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= '0;
      rs_busy      <= 1'b0;
      rt_busy      <= 1'b0;
      rsv_conflict <= 1'b0;
    end else begin
      busy         <= busy_next;
      rsv_conflict <= rsv_eff && busy[rsv_reg];
      if (rd_en) begin
        rs_busy <= busy_next[rs];
        rt_busy <= busy_next[rt];
      end
    end
  end

endmodule

// File: rtl/regfile_pipe.sv
// regfile_pipe: parametrised register file with registered reads,
// same-cycle write forwarding and a busy scoreboard.
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset, clears array, busy bits, outputs
//   bus  : regfile_pipe_if.slave (read, reserve and writeback ports)
// Optional: REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_pipe
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter  int unsigned REG_CNT = DEFAULT_REG_CNT,
  localparam int unsigned ADDR_W  = $clog2(REG_CNT)
) (
  input logic           clk,
  input logic           rst,
  regfile_pipe_if.slave bus
);

  logic [DATA_W-1:0] registers [REG_CNT];
  logic              wr_eff;
  logic [DATA_W-1:0] rs_next;
  logic [DATA_W-1:0] rt_next;

  always_comb begin
`ifdef REGFILE_ZERO_REG_EN
    wr_eff = bus.is_write && (bus.reg_write != ADDR_W'(ZERO_REG_IDX));
`else
    wr_eff = bus.is_write;
`endif
    rs_next = (wr_eff && (bus.reg_write == bus.rs)) ? bus.write_val : registers[bus.rs];
    rt_next = (wr_eff && (bus.reg_write == bus.rt)) ? bus.write_val : registers[bus.rt];
`ifdef REGFILE_ZERO_REG_EN
    if (bus.rs == ADDR_W'(ZERO_REG_IDX)) rs_next = '0;
    if (bus.rt == ADDR_W'(ZERO_REG_IDX)) rt_next = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_CNT; i++) registers[i] <= '0;
    end else if (wr_eff) begin
      registers[bus.reg_write] <= bus.write_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rs_val <= '0;
      bus.rt_val <= '0;
    end else if (bus.rd_en) begin
      bus.rs_val <= rs_next;
      bus.rt_val <= rt_next;
    end
  end

  regfile_scoreboard #(
    .REG_CNT(REG_CNT)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .rs           (bus.rs),
    .rt           (bus.rt),
    .rd_en        (bus.rd_en),
    .rsv_en       (bus.rsv_en),
    .rsv_reg      (bus.rsv_reg),
    .is_write     (bus.is_write),
    .reg_write    (bus.reg_write),
    .rs_busy      (bus.rs_busy),
    .rt_busy      (bus.rt_busy),
    .rsv_conflict (bus.rsv_conflict)
  );

endmodule
